// File: rtl/sevseg_scan_ctrl.sv
// Multiplexed seven-segment scanner for a common-anode display with per-digit
// enables, decimal points, leading-zero blanking, PWM dimming and frame snapshots.
module sevseg_scan_ctrl #(
    parameter int DIGITS   = 8,
    parameter int DIV_W    = 16,
    parameter int BRIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [4*DIGITS-1:0]   hex_val,
    input  logic [DIGITS-1:0]     dp_val,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  lz_blank,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     anodes_n,
    output logic                  frame_start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [DIV_W-1:0]    div_cnt_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                load_pending_reg;
    logic [3:0]          shadow_hex_reg [DIGITS];
    logic [DIGITS-1:0]   shadow_dp_reg;
    logic [DIGITS-1:0]   shadow_en_reg;
    logic [DIGITS-1:0]   shadow_lz_reg;

    logic [6:0]          seg_reg,      seg_next;
    logic                dp_reg,       dp_next;
    logic [DIGITS-1:0]   anodes_reg,   anodes_next;
    logic                frame_start_reg;

    logic                tick;
    logic                load;
    logic                pwm_on;
    logic                vis;
    logic [DIGITS-1:0]   lz_mask;
    logic                zero_above;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h18;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick = &div_cnt_reg;
    // A frame boundary is the tick that wraps the last digit back to digit 0.
    assign load = load_pending_reg | (tick & (idx_reg == LAST_IDX));

    // Walk down from the top digit; blanking stops at the first non-zero nibble or lit dp.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (hex_val[4*i +: 4] == 4'h0) & ~dp_val[i];
            lz_mask[i] = lz_blank & zero_above;
        end
    end

    assign pwm_on = (&brightness) | (div_cnt_reg[DIV_W-1 -: BRIGHT_W] < brightness);
    assign vis    = shadow_en_reg[idx_reg] & ~shadow_lz_reg[idx_reg] & pwm_on;

    always_comb begin
        seg_next    = 7'h7F;
        dp_next     = 1'b1;
        anodes_next = '1;
        if (vis) begin
            seg_next    = hex_to_seg(shadow_hex_reg[idx_reg]);
            dp_next     = ~shadow_dp_reg[idx_reg];
            anodes_next = ~(DIGITS'(1) << idx_reg);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            div_cnt_reg      <= '0;
            idx_reg          <= '0;
            load_pending_reg <= 1'b1;
        end else begin
            div_cnt_reg      <= div_cnt_reg + 1'b1;
            load_pending_reg <= 1'b0;
            if (tick)
                idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < DIGITS; i++)
                shadow_hex_reg[i] <= 4'h0;
            shadow_dp_reg <= '0;
            shadow_en_reg <= '0;
            shadow_lz_reg <= '0;
        end else if (load) begin
            for (int i = 0; i < DIGITS; i++)
                shadow_hex_reg[i] <= hex_val[4*i +: 4];
            shadow_dp_reg <= dp_val;
            shadow_en_reg <= digit_en;
            shadow_lz_reg <= lz_mask;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            seg_reg         <= 7'h7F;
            dp_reg          <= 1'b1;
            anodes_reg      <= '1;
            frame_start_reg <= 1'b0;
        end else begin
            seg_reg         <= seg_next;
            dp_reg          <= dp_next;
            anodes_reg      <= anodes_next;
            frame_start_reg <= load;
        end
    end

    assign seg_n       = seg_reg;
    assign dp_n        = dp_reg;
    assign anodes_n    = anodes_reg;
    assign frame_start = frame_start_reg;

endmodule
